// File: rtl/cache_pkg.sv
// Shared constants, address field offsets and controller state encoding for the
// cache data SRAM request controller.
package cache_pkg;

   localparam int INDEX_W   = 6;
   localparam int WORD_W    = 64;
   localparam int LINE_W    = 2 * WORD_W;
   localparam int STRB_W    = WORD_W / 8;
   localparam int ADDR_W    = INDEX_W + 4;
   localparam int INDEX_LSB = 4;
   localparam int HALF_BIT  = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } ctrl_state_e;

   // Picks the 64-bit half of a line that a request addressed.
   function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                     input logic              half);
      return half ? line[LINE_W-1 -: WORD_W] : line[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/cache_sram_bwen_gen.sv
// Expands per-byte write strobes for one 64-bit half into the SRAM's
// active-low bit write-enable mask across the full line.
module cache_sram_bwen_gen
   import cache_pkg::*;
(
   input  logic              enable,
   input  logic              half,
   input  logic [STRB_W-1:0] wstrb,
   output logic [LINE_W-1:0] bwen
);

   always_comb begin
      // NOTE: the all-ones default comes first so every path assigns bwen and no latch is inferred.
      bwen = '1;
      if (enable) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) begin
               bwen[int'(half) * WORD_W + 8 * i +: 8] = 8'h00;
            end
         end
      end
   end

endmodule

// File: rtl/cache_sram_req_ctrl.sv
// Initiator-side controller for the 64x128 cache data SRAM. Defining
// CACHE_SRAM_RESP_BUF_EN swaps the single-read FSM for a pipelined 2-entry response FIFO.
module cache_sram_req_ctrl
   import cache_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic [INDEX_W-1:0] sram_a,
   output logic [LINE_W-1:0] sram_bwen,
   output logic [LINE_W-1:0] sram_d,
   input  logic [LINE_W-1:0] sram_q
);

   logic               fire;
   logic               wr_fire;
   logic               rd_fire;
   logic               wr_access;
   logic [INDEX_W-1:0] line_index;
   logic               half_sel;
   logic               half_q;
   logic               unused_addr_bits;

   assign line_index       = req_addr[INDEX_LSB +: INDEX_W];
   assign half_sel         = req_addr[HALF_BIT];
   assign unused_addr_bits = ^req_addr[HALF_BIT-1:0];

   assign fire      = req_valid && req_ready;
   assign wr_fire   = fire && req_wen;
   assign rd_fire   = fire && !req_wen;
   // A write with no strobes completes the handshake but never touches the array.
   assign wr_access = wr_fire && (req_wstrb != '0);

   assign sram_cen = !(rd_fire || wr_access);
   assign sram_wen = !wr_fire;
   assign sram_a   = fire ? line_index : '0;
   assign sram_d   = wr_fire ? {2{req_wdata}} : '0;

   cache_sram_bwen_gen u_bwen_gen (
      .enable (wr_fire),
      .half   (half_sel),
      .wstrb  (req_wstrb),
      .bwen   (sram_bwen)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         half_q <= 1'b0;
      end else if (rd_fire) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         half_q <= half_sel;
      end
   end

`ifdef CACHE_SRAM_RESP_BUF_EN

   logic              inflight;
   logic [WORD_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        slots_used;
   logic [WORD_W-1:0] q_word;
   logic              pop;
   logic              fifo_pop;
   logic              push;

   assign q_word = select_word(sram_q, half_q);

   // An empty FIFO forwards the returning read word straight to the consumer.
   assign resp_valid = !reset && ((count != 2'd0) || inflight);
   assign resp_rdata = (count != 2'd0) ? fifo_mem[rd_ptr] :
                       (inflight ? q_word : '0);

   assign pop      = resp_valid && resp_ready;
   assign fifo_pop = pop && (count != 2'd0);
   assign push     = inflight && !(pop && (count == 2'd0));

   assign slots_used = count + 2'(inflight) - 2'(pop);
   assign req_ready  = !reset && (req_wen || (slots_used < 2'd2));

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= rd_fire;
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(fifo_pop);
      end
   end

   // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= q_word;
      end
   end

`else

   ctrl_state_e state;
   logic        idle_q;

   assign req_ready = idle_q && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         idle_q     <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_fire) begin
                  state  <= RD_WAIT;
                  idle_q <= 1'b0;
               end
            end
            RD_WAIT: begin
               resp_rdata <= select_word(sram_q, half_q);
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  idle_q     <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               idle_q     <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

`endif

endmodule

// File: doc/cache_sram_req_ctrl.md
Name: cache_sram_req_ctrl

Overview:
- Initiator-side controller for the 64x128 single-port cache data SRAM.
- Accepts 64-bit word read/write requests from the cache pipeline over a valid/ready handshake.
- Drives the SRAM's active-low CEN/WEN/BWEN pins and address/data.
- Captures the one-cycle-latency read data and returns the selected 64-bit half over a valid/ready response channel.

Parameters:
- INDEX_W, 6, SRAM address width (64 lines)
- LINE_W, 128, SRAM data/BWEN width
- WORD_W, 64, request/response word width; LINE_W = 2*WORD_W fixed

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_wen  in  1  1=write, 0=read
- req_addr  in  INDEX_W+4  byte address; [INDEX_W+3:4]=line index, [3]=half select, [2:0] ignored
- req_wdata  in  WORD_W  write data
- req_wstrb  in  WORD_W/8  byte enables, active-high
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  WORD_W  read word
- sram_cen  out  1  chip enable, active-low
- sram_wen  out  1  write enable, active-low
- sram_a  out  INDEX_W  line address
- sram_bwen  out  LINE_W  bit write enable, active-low
- sram_d  out  LINE_W  write data
- sram_q  in  LINE_W  read data, valid the cycle after a read access

Behaviour:
- SRAM pins are combinational from the accept handshake (fire = req_valid&&req_ready); the access occurs at the same clock edge.
- No fire: sram_cen=1, sram_wen=1, sram_bwen=all ones, sram_a=0, sram_d=0.
- Write fire:
  - sram_cen=0, sram_wen=0, sram_a=index, sram_d={req_wdata,req_wdata}.
  - sram_bwen bit (half*64+8i+j)=0 iff req_wstrb[i]; all other bits 1.
  - If req_wstrb==0: request is accepted but sram_cen stays 1 (no access).
  - Writes produce no response.
- Read fire: sram_cen=0, sram_wen=1, sram_a=index, sram_bwen=all ones; latch the half-select bit.
- FSM:
  - IDLE: req_ready=1. Read fire -> RD_WAIT. Write fire -> stays IDLE.
  - RD_WAIT: req_ready=0. Capture sram_q half (hi if latched half=1) into resp register -> RESP.
  - RESP: req_ready=0, resp_valid=1, resp_rdata stable. resp_ready -> IDLE.
- Latency: resp_valid rises 2 cycles after the read fire edge.
- Throughput: 1 write/cycle; 1 read per 3 cycles minimum.
- Ordering: a write accepted after a read has its access at a later edge than the read, so the read returns old data.
- Reset (any state, including mid-read): state=IDLE, resp_valid=0, resp_rdata=0, in-flight read dropped; SRAM pins idle in the reset cycle (req_ready=0 while reset=1).

Optional Feature:
- Macro CACHE_SRAM_RESP_BUF_EN.
- Defined:
  - FSM replaced by a read-in-flight flag plus a 2-entry response FIFO (head = resp_rdata).
  - Read accepted iff inflight + occupancy < 2, counting a same-cycle resp pop (pop frees a slot the same cycle).
  - Writes always accepted.
  - Back-to-back reads sustain 1/cycle with resp_ready=1; resp_valid 1 cycle after the read fire edge.
  - Reset clears FIFO and flag.
- Undefined: FSM behaviour above.

Decomposition:
- Shared package (cache_pkg): INDEX_W/LINE_W/WORD_W constants, address field offsets, FSM state enum (IDLE, RD_WAIT, RESP).
- Natural sub-module: cache_sram_bwen_gen (combinational wstrb + half -> active-low LINE_W mask). The FIFO stays inline.

Test Plan:
- Write addr=0x0A8 (idx 10, half 1), wdata=0x1122334455667788, wstrb=0x0F -> cen=0, wen=0, a=10, bwen[95:64]=0, all other bwen bits 1, one cycle.
- Read addr=0x0A8 after that write, SRAM model preloaded 0 -> resp_valid 2 cycles after fire, rdata=0x0000000055667788.
- Read held in RESP with resp_ready=0 for 5 cycles -> rdata stable, req_ready=0, no SRAM access; resp_ready=1 -> IDLE next cycle.
- Write with wstrb=0x00 -> req_ready handshake completes, sram_cen stays 1, SRAM contents unchanged.
- Reset asserted in RD_WAIT -> next cycle resp_valid=0, state IDLE, no response ever emitted for the dropped read.
- CACHE_SRAM_RESP_BUF_EN, 4 back-to-back reads of idx 1..4 (lines preloaded, half 0 = idx), resp_ready=1 -> responses 1,2,3,4 on consecutive cycles, no req_ready stall.
